// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, address/instruction types and PC increment helper
package fetch_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 19;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // Wraps 4095 -> 0 by construction of the 12-bit type
  function automatic addr_t addr_inc(input addr_t a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch control, instruction-memory and decode-side signal bundle
interface fetch_if;
  import fetch_pkg::*;

  logic   stall;
  logic   jmp;
  logic   call;
  logic   ret;
  addr_t  target;
  addr_t  address;
  instr_t instruction;
  instr_t ir;
  logic   ir_valid;
  logic   stack_ovf;
  logic   stack_unf;

  modport master (
    output stall, jmp, call, ret, target, instruction,
    input  address, ir, ir_valid, stack_ovf, stack_unf
  );

  modport slave (
    input  stall, jmp, call, ret, target, instruction,
    output address, ir, ir_valid, stack_ovf, stack_unf
  );

endinterface

// File: rtl/fetch_rstack.sv
// rtl/fetch_rstack.sv - return-address stack, occupancy 0..DEPTH with exact full/empty
module fetch_rstack
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  addr_t push_data,
  output addr_t top,
  output logic  full,
  output logic  empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit so a full stack is distinct from an empty one
  logic [PW:0]   ptr;
  logic [PW-1:0] top_idx;
  addr_t         mem [DEPTH];

  assign full    = (ptr == (PW+1)'(DEPTH));
  assign empty   = (ptr == '0);
  assign top_idx = ptr[PW-1:0] - 1'b1;
  assign top     = mem[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[ptr[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, redirect, IR capture; return stack under FETCH_RSTACK_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave bus
);

  addr_t  pc;
  addr_t  pc_inc;
  addr_t  pc_next;
  instr_t ir_q;
  logic   ir_valid_q;
  logic   ovf_q;
  logic   unf_q;
  logic   flush;
  logic   set_ovf;
  logic   set_unf;
  logic   take_ret;
  logic   take_call;
  logic   take_jmp;

  assign pc_inc    = addr_inc(pc);
  assign take_ret  = !bus.stall && bus.ret;
  assign take_call = !bus.stall && bus.call && !bus.ret;
  assign take_jmp  = !bus.stall && bus.jmp && !bus.call && !bus.ret;

`ifdef FETCH_RSTACK_EN
  logic  st_full;
  logic  st_empty;
  addr_t st_top;

  fetch_rstack #(.DEPTH(STACK_DEPTH)) u_rstack (
    .clk       (clk),
    .rst       (rst),
    .push      (take_call),
    .pop       (take_ret),
    .push_data (pc_inc),
    .top       (st_top),
    .full      (st_full),
    .empty     (st_empty)
  );

  always_comb begin
    pc_next = pc_inc;
    flush   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (take_ret) begin
      flush = 1'b1;
      if (st_empty) set_unf = 1'b1;
      else          pc_next = st_top;
    end else if (take_call) begin
      pc_next = bus.target;
      flush   = 1'b1;
      set_ovf = st_full;
    end else if (take_jmp) begin
      pc_next = bus.target;
      flush   = 1'b1;
    end
  end
`else
  // Without a stack, ret degrades to a plain sequential fetch
  always_comb begin
    pc_next = pc_inc;
    flush   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (take_call || take_jmp) begin
      pc_next = bus.target;
      flush   = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (!bus.stall) begin
      pc         <= pc_next;
      ir_q       <= bus.instruction;
      ir_valid_q <= !flush;
      ovf_q      <= ovf_q | set_ovf;
      unf_q      <= unf_q | set_unf;
    end
  end

  assign bus.address   = pc;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit; covers both FETCH_RSTACK_EN builds
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
`ifdef FETCH_RSTACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic   valid;
    instr_t word;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if bus ();

  fetch_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic instr_t mem_word(input addr_t a);
    return {a[6:0] ^ 7'h5a, a};
  endfunction

  assign bus.instruction = mem_word(bus.address);

  sb_t    sb_q[$];
  int     pass_cnt  = 0;
  int     fail_cnt  = 0;
  int     total_cnt = 0;
  addr_t  cur_addr;
  logic   exp_valid;
  instr_t exp_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic j, input logic c, input logic r,
                      input addr_t tgt, input addr_t exp_addr, input string tag);
    sb_t e;
    bus.stall  = s;
    bus.jmp    = j;
    bus.call   = c;
    bus.ret    = r;
    bus.target = tgt;
    if (!s) begin
      e.valid = !(j || c || (r && STK));
      e.word  = mem_word(cur_addr);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.stall = 1'b0;
    bus.jmp   = 1'b0;
    bus.call  = 1'b0;
    bus.ret   = 1'b0;
    chk({tag, " address"}, 32'(bus.address), 32'(exp_addr));
    if (!s) begin
      if (sb_q.size() == 0) begin
        chk({tag, " scoreboard"}, 32'(0), 32'(1));
      end else begin
        e         = sb_q.pop_front();
        exp_valid = e.valid;
        exp_ir    = e.word;
      end
    end
    chk({tag, " ir_valid"}, 32'(bus.ir_valid), 32'(exp_valid));
    chk({tag, " ir"}, 32'(bus.ir), 32'(exp_ir));
    cur_addr = exp_addr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_t ret_addr [DEPTH+1];
    addr_t t;

    bus.stall  = 1'b0;
    bus.jmp    = 1'b0;
    bus.call   = 1'b0;
    bus.ret    = 1'b0;
    bus.target = '0;
    #2;
    chk("reset address", 32'(bus.address), 32'(0));
    chk("reset ir", 32'(bus.ir), 32'(0));
    chk("reset ir_valid", 32'(bus.ir_valid), 32'(0));
    chk("reset ovf", 32'(bus.stack_ovf), 32'(0));
    chk("reset unf", 32'(bus.stack_unf), 32'(0));
    #10;
    rst       = 1'b0;
    cur_addr  = '0;
    exp_valid = 1'b0;
    exp_ir    = '0;

    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, '0, addr_t'(i), "seq");

    step(0, 1, 0, 0, 12'h100, 12'h100, "jmp");
    step(0, 0, 0, 0, '0, 12'h101, "jmp follow");

    step(0, 1, 0, 0, 12'h010, 12'h010, "jmp to call site");
    step(0, 0, 1, 0, 12'h200, 12'h200, "call");
    step(0, 0, 0, 0, '0, 12'h201, "callee");
    step(0, 0, 0, 0, '0, 12'h202, "callee");
    step(0, 0, 0, 0, '0, 12'h203, "callee");
    step(0, 0, 0, 1, '0, STK ? 12'h011 : 12'h204, "ret");
    step(0, 0, 0, 0, '0, STK ? 12'h012 : 12'h205, "after ret");
    chk("call/ret ovf", 32'(bus.stack_ovf), 32'(0));
    chk("call/ret unf", 32'(bus.stack_unf), 32'(0));

    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 12'h300, cur_addr, "stall hold");
    step(0, 1, 0, 0, 12'h300, 12'h300, "jmp after stall");
    step(0, 0, 0, 0, '0, 12'h301, "after stall jmp");

    step(0, 1, 0, 0, 12'hfff, 12'hfff, "jmp to top");
    step(0, 0, 0, 0, '0, 12'h000, "wrap");
    step(0, 0, 0, 0, '0, 12'h001, "after wrap");

`ifdef FETCH_RSTACK_EN
    step(0, 1, 0, 0, 12'h050, 12'h050, "jmp to nest base");
    for (int i = 0; i <= DEPTH; i++) begin
      ret_addr[i] = cur_addr + 12'd1;
      t = addr_t'(12'h400 + i * 16);
      step(0, 0, 1, 0, t, t, "nested call");
      if (i == DEPTH - 1) chk("ovf when exactly full", 32'(bus.stack_ovf), 32'(0));
    end
    chk("ovf after extra call", 32'(bus.stack_ovf), 32'(1));
    for (int i = DEPTH - 1; i >= 0; i--) step(0, 0, 0, 1, '0, ret_addr[i], "nested ret");
    chk("unf before extra ret", 32'(bus.stack_unf), 32'(0));
    t = cur_addr + 12'd1;
    step(0, 0, 0, 1, '0, t, "ret on empty");
    chk("unf after extra ret", 32'(bus.stack_unf), 32'(1));
    chk("ovf sticky", 32'(bus.stack_ovf), 32'(1));
`else
    step(0, 0, 1, 0, 12'h040, 12'h040, "call as jmp");
    step(0, 0, 0, 0, '0, 12'h041, "after call");
    step(0, 0, 0, 1, '0, 12'h042, "ret as seq");
    step(0, 0, 0, 0, '0, 12'h043, "after ret");
    chk("nostack ovf", 32'(bus.stack_ovf), 32'(0));
    chk("nostack unf", 32'(bus.stack_unf), 32'(0));
`endif

    // Reset lands between edges while a call is being requested
    bus.call   = 1'b1;
    bus.target = 12'h500;
    #2;
    rst = 1'b1;
    #1;
    chk("midcall reset address", 32'(bus.address), 32'(0));
    chk("midcall reset ir_valid", 32'(bus.ir_valid), 32'(0));
    chk("midcall reset ir", 32'(bus.ir), 32'(0));
    chk("midcall reset ovf", 32'(bus.stack_ovf), 32'(0));
    chk("midcall reset unf", 32'(bus.stack_unf), 32'(0));
    bus.call = 1'b0;
    #1;
    rst = 1'b0;
    sb_q.delete();
    cur_addr  = '0;
    exp_valid = 1'b0;
    exp_ir    = '0;
    step(0, 0, 0, 1, '0, 12'h001, "ret after reset");
    chk("unf after reset ret", 32'(bus.stack_unf), 32'(STK));
    step(0, 0, 0, 0, '0, 12'h002, "seq after reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter STACK_DEPTH, default 8, giving the number of return-stack entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-004 The block SHALL have port stall, input, 1, holding PC, IR and stack when high.
REQ-005 The block SHALL have port jmp, input, 1, requesting an unconditional redirect to target.
REQ-006 The block SHALL have port call, input, 1, requesting a push of PC+1 and a redirect to target.
REQ-007 The block SHALL have port ret, input, 1, requesting a pop and a redirect to the popped address.
REQ-008 The block SHALL have port target, input, 12, the redirect address for jmp/call.
REQ-009 The block SHALL have port address, output, 12, the instruction-memory address, equal to the PC register.
REQ-010 The block SHALL have port instruction, input, 19, the instruction-memory read data for address.
REQ-011 The block SHALL have port ir, output, 19, the registered instruction for decode.
REQ-012 The block SHALL have port ir_valid, output, 1, high when ir holds a non-flushed instruction.
REQ-013 The block SHALL have ports stack_ovf and stack_unf, output, 1 each, sticky overflow/underflow flags.

Function
REQ-014 When stall is low, PC SHALL update every cycle with priority ret > call > jmp > sequential (PC+1).
REQ-015 PC+1 SHALL be 12-bit modulo: 4095 -> 0.
REQ-016 When stall is low, ir SHALL capture instruction (one-cycle latency from address to ir).
REQ-017 ir_valid SHALL go low for exactly the cycle after any accepted jmp/call/ret (flush of the wrong-path word) and be high otherwise when unstalled.
REQ-018 When stall is high, PC, ir, ir_valid, stack and flags SHALL hold; jmp/call/ret SHALL be ignored (requester keeps them asserted).
REQ-019 call SHALL push PC+1 (mod 4096); if the stack is full, the push is dropped, stack_ovf sets, and the redirect still occurs.
REQ-020 ret SHALL pop the top entry into PC; if the stack is empty, stack_unf sets and PC advances to PC+1 (no-op).
REQ-021 Stack occupancy SHALL range 0..STACK_DEPTH; full and empty are exact, with no wrap-around of the stack pointer.
REQ-022 stack_ovf/stack_unf SHALL remain set until reset.

Reset
REQ-023 On rst high, asynchronously: PC=0, ir=0, ir_valid=0, stack pointer=0, stack_ovf=0, stack_unf=0; stack contents are don't-care.
REQ-024 The first cycle after rst deasserts SHALL present address 0; ir_valid SHALL rise at the following edge.
REQ-025 Reset mid-call/ret SHALL discard the operation completely.

Configuration
REQ-026 Macro FETCH_RSTACK_EN defined: the return stack and flags SHALL behave as above.
REQ-027 Macro FETCH_RSTACK_EN undefined: no stack storage; call SHALL act as jmp; ret SHALL act as sequential PC+1 with no flush; stack_ovf/stack_unf SHALL be tied 0.

Structure
REQ-028 Package fetch_pkg SHALL hold ADDR_W=12, INSTR_W=19, addr_t and instr_t typedefs.
REQ-029 The return stack SHALL be sub-module fetch_rstack (push/pop/full/empty/top ports).

Verification
REQ-030 Reset then 4 free-running cycles -> address 0,1,2,3; ir_valid low at first edge, then high with ir = mem[0], mem[1].
REQ-031 jmp target=0x100 at PC 5 -> next address 0x100, ir_valid low one cycle, then ir = mem[0x100].
REQ-032 call target=0x200 at PC 0x010, then ret at 0x203 -> PC 0x011; stack empty afterwards, no flags.
REQ-033 STACK_DEPTH+1 nested calls -> stack_ovf=1 after the last; then STACK_DEPTH+1 rets -> last ret sets stack_unf=1 and gives PC+1.
REQ-034 stall high 3 cycles with jmp asserted -> address/ir frozen; jmp taken on the first unstalled edge; PC=4095 unstalled -> 0.
REQ-035 Build without FETCH_RSTACK_EN: call 0x040 -> PC 0x040; ret -> PC+1, ir_valid stays high, flags 0.
